cam_stream_gen: RTL and testbench
=================================

// Module: cam_stream_gen
// PURPOSE
//  Synthesizable, parametrised OV7670-style camera emulator. Drives CAM_pclk, CAM_vsync, CAM_href
//  and CAM_px_data (RGB444, two bytes per pixel) with selectable test patterns.
//  Replaces hand-written testbench stimulus. Feeds the capture path on the board when no sensor is fitted.
// PARAMETERS
//  H_PIXELS       160  active pixels per line (2 byte slots each)
//  V_LINES        120  active lines per frame
//  H_BLANK_BYTES  4    byte slots with href low at the end of every line
//  V_BLANK_LINES  4    blank lines at frame start (href held low)
//  VSYNC_LINES    2    lines 0..VSYNC_LINES-1 of the blank lines carry vsync high; must be <= V_BLANK_LINES
//  PCLK_DIV       4    clk cycles per CAM_pclk period; even, >= 2
//  STRIPE_W       2    pattern cell width in pixels (x)
//  STRIPE_H       2    pattern cell height in lines (y)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   asynchronous, active-low reset
//  enable       in   1   1 = generate frames continuously; sampled only at a frame boundary
//  mode         in   2   0 solid A, 1 vertical stripes, 2 horizontal stripes, 3 checker
//  color_a      in   12  RGB444 {R,G,B}
//  color_b      in   12  RGB444 {R,G,B}
//  CAM_pclk     out  1   emulated pixel clock, 50 % duty
//  CAM_vsync    out  1   frame sync, active high
//  CAM_href     out  1   line valid, active high
//  CAM_px_data  out  8   byte 0 = {4'h0,R}, byte 1 = {G,B}
//  frame_done   out  1   one-clk pulse when the last byte slot of a frame ends
//  frame_cnt    out  8   frames completed; wraps 255 -> 0
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, all counters 0, state IDLE, CAM_pclk low.
//  - CAM_pclk: a divider toggles it every PCLK_DIV/2 clk cycles, in every state including IDLE.
//    It starts with the low half after reset.
//  - All other outputs change only in the clk cycle where CAM_pclk falls.
//    They are therefore stable at every CAM_pclk rising edge.
//  - byte_cnt counts 0 .. 2*H_PIXELS+H_BLANK_BYTES-1, one step per pclk period.
//    line_cnt counts 0 .. V_BLANK_LINES+V_LINES-1.
//  - States:
//    - IDLE: vsync=href=data=0.
//    - IDLE -> FRAME on a pclk falling edge with enable=1.
//    - FRAME -> FRAME (enable=1) or IDLE (enable=0) at the end of the last slot of the last line.
//    - Deasserting enable mid-frame always completes the current frame.
//  - FRAME start: mode, color_a and color_b are latched. Changes mid-frame take effect next frame.
//  - vsync = 1 while line_cnt < VSYNC_LINES.
//    href = 1 while line_cnt >= V_BLANK_LINES and byte_cnt < 2*H_PIXELS.
//  - px_data = 8'h00 whenever href = 0.
//  - Pattern colour: x = byte_cnt>>1, y = line_cnt-V_BLANK_LINES.
//    sx = (x/STRIPE_W)&1, sy = (y/STRIPE_H)&1. The B colour is used for:
//    - mode 0: never (always A)
//    - mode 1: sx
//    - mode 2: sy
//    - mode 3: sx^sy
//  - Even byte slot sends the high byte. Odd byte slot sends the low byte.
//  - frame_done pulses and frame_cnt increments in the same clk on that final falling edge.
// STRUCTURE
//  - cam_gen_pkg:
//    - MODE_SOLID/VSTRIPE/HSTRIPE/CHECKER constants
//    - rgb444_t typedef
//    - function rgb444_byte(color, hi)
//  - Counter widths via $clog2 of the parameter-derived maxima.
//  - Sub-module cam_pattern_px: combinational (x, y, mode, a, b) -> rgb444. Instantiated once.
// TESTING
//  Bench parameters: H_PIXELS=4, V_LINES=2, H_BLANK_BYTES=2, V_BLANK_LINES=2, VSYNC_LINES=1, PCLK_DIV=4.
//  This gives 10-slot lines, 4-line frames, 160 clk per frame.
//  1 Reset held, then released with enable=0:
//    -> CAM_pclk period is 4 clk.
//    -> vsync/href/data stay 0 and frame_cnt=0.
//  2 enable=1, mode=0, color_a=12'hF00:
//    -> per frame vsync=1 for 10 pclk.
//    -> href=1 for 8 pclk in lines 2,3.
//    -> bytes 0F,00 repeated.
//    -> frame_done pulse every 160 clk.
//  3 mode=1, a=12'h00F, b=12'h0F0:
//    -> line bytes 00,0F,00,0F,00,F0,00,F0 then 2 slots href=0 data=00.
//  4 mode=3, same colours:
//    -> line 2 as in test 3.
//    -> line 3 identical (sy=0 for y=0,1).
//    -> with STRIPE_H=1, line 3 = 00,F0,00,F0,00,0F,00,0F.
//  5 mode changed 1->2 mid-frame:
//    -> current frame keeps vertical stripes.
//    -> the next frame is horizontal stripes.
//  6 enable dropped mid-frame:
//    -> the frame completes and frame_cnt increments once, then IDLE.
//    Also: rst pulsed mid-line -> all outputs 0 within the same clk.
//    Also: 256 frames -> frame_cnt wraps to 0.

Source files
------------

// File: rtl/cam_gen_pkg.sv
// Shared types and helpers for the camera stream emulator.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cam_gen_pkg;

  localparam logic [1:0] MODE_SOLID   = 2'd0;
  localparam logic [1:0] MODE_VSTRIPE = 2'd1;
  localparam logic [1:0] MODE_HSTRIPE = 2'd2;
  localparam logic [1:0] MODE_CHECKER = 2'd3;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb444_t;

  // Per-frame configuration, captured once at frame start.
  typedef struct packed {
    logic [1:0] mode;
    rgb444_t    a;
    rgb444_t    b;
  } cam_cfg_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } cam_state_e;

  // OV7670 RGB444 wire order: first byte carries R, second carries G and B.
  function automatic logic [7:0] rgb444_byte(input rgb444_t color, input logic hi);
    return hi ? {4'h0, color.r} : {color.g, color.b};
  endfunction

endpackage

// File: rtl/cam_pattern_px.sv
// Test-pattern colour for one pixel position, chosen from two colours by mode.
// Latency: combinational.
// Backpressure: none.
module cam_pattern_px
  import cam_gen_pkg::*;
#(
  parameter int X_W      = 8,
  parameter int Y_W      = 8,
  parameter int STRIPE_W = 2,
  parameter int STRIPE_H = 2
) (
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  input  logic [1:0]     mode,
  input  rgb444_t        color_a,
  input  rgb444_t        color_b,
  output rgb444_t        px
);

  logic sx;
  logic sy;
  logic use_b;

  // Cell parity in x and y selects colour B according to the pattern mode.
  always_comb begin
    sx    = ((int'(x) / STRIPE_W) % 2) == 1;
    sy    = ((int'(y) / STRIPE_H) % 2) == 1;
    use_b = 1'b0;
    case (mode)
      MODE_SOLID:   use_b = 1'b0;
      MODE_VSTRIPE: use_b = sx;
      MODE_HSTRIPE: use_b = sy;
      default:      use_b = sx ^ sy;
    endcase
    px = use_b ? color_b : color_a;
  end

endmodule

// File: rtl/cam_stream_gen.sv
// OV7670-style camera emulator: pclk/vsync/href/RGB444 bytes with test patterns.
// Latency: outputs registered; they update only in the clk where CAM_pclk falls.
// Backpressure: none, free-running source; enable is honoured at frame boundaries.
module cam_stream_gen
  import cam_gen_pkg::*;
#(
  parameter int H_PIXELS      = 160,
  parameter int V_LINES       = 120,
  parameter int H_BLANK_BYTES = 4,
  parameter int V_BLANK_LINES = 4,
  parameter int VSYNC_LINES   = 2,
  parameter int PCLK_DIV      = 4,
  parameter int STRIPE_W      = 2,
  parameter int STRIPE_H      = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [11:0] color_a,
  input  logic [11:0] color_b,
  output logic        CAM_pclk,
  output logic        CAM_vsync,
  output logic        CAM_href,
  output logic [7:0]  CAM_px_data,
  output logic        frame_done,
  output logic [7:0]  frame_cnt
);

  localparam int LINE_BYTES  = 2 * H_PIXELS + H_BLANK_BYTES;
  localparam int FRAME_LINES = V_BLANK_LINES + V_LINES;
  localparam int HALF_DIV    = PCLK_DIV / 2;
  localparam int BYTE_W      = (LINE_BYTES > 1) ? $clog2(LINE_BYTES) : 1;
  localparam int LINE_W      = (FRAME_LINES > 1) ? $clog2(FRAME_LINES) : 1;
  localparam int DIV_W       = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

  logic [DIV_W-1:0]  div_cnt;
  logic              div_last;
  logic              pclk_fall;

  cam_state_e        state, state_nxt;
  logic [BYTE_W-1:0] byte_cnt, byte_nxt;
  logic [LINE_W-1:0] line_cnt, line_nxt;
  cam_cfg_t          cfg, cfg_nxt, cfg_in;
  logic [7:0]        frame_cnt_nxt;
  logic              done_nxt;
  logic              vsync_nxt;
  logic              href_nxt;
  logic [7:0]        data_nxt;
  logic              last_byte;
  logic              last_line;
  rgb444_t           px;

  assign div_last  = (int'(div_cnt) == HALF_DIV - 1);
  // Every state transition is aligned to the falling edge so outputs are
  // settled a full half period before the capture side's rising edge.
  assign pclk_fall = div_last && CAM_pclk;
  assign last_byte = (int'(byte_cnt) == LINE_BYTES - 1);
  assign last_line = (int'(line_cnt) == FRAME_LINES - 1);
  assign cfg_in    = {mode, color_a, color_b};

  // Free-running pclk divider, low half first out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_cnt  <= '0;
      CAM_pclk <= 1'b0;
    end else if (div_last) begin
      div_cnt  <= '0;
      CAM_pclk <= ~CAM_pclk;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // Pattern evaluated at the slot about to be presented, so the output bytes
  // register together with the counters.
  cam_pattern_px #(
    .X_W      (BYTE_W),
    .Y_W      (LINE_W),
    .STRIPE_W (STRIPE_W),
    .STRIPE_H (STRIPE_H)
  ) u_pattern (
    .x       (byte_nxt >> 1),
    .y       (line_nxt - LINE_W'(V_BLANK_LINES)),
    .mode    (cfg_nxt.mode),
    .color_a (cfg_nxt.a),
    .color_b (cfg_nxt.b),
    .px      (px)
  );

  // Next-state, slot counters, config capture and next output values.
  always_comb begin
    state_nxt     = state;
    byte_nxt      = byte_cnt;
    line_nxt      = line_cnt;
    cfg_nxt       = cfg;
    frame_cnt_nxt = frame_cnt;
    done_nxt      = 1'b0;
    if (pclk_fall) begin
      case (state)
        ST_IDLE: begin
          if (enable) begin
            state_nxt = ST_FRAME;
            byte_nxt  = '0;
            line_nxt  = '0;
            cfg_nxt   = cfg_in;
          end
        end
        ST_FRAME: begin
          if (last_byte) begin
            byte_nxt = '0;
            if (last_line) begin
              line_nxt      = '0;
              done_nxt      = 1'b1;
              frame_cnt_nxt = frame_cnt + 8'd1;
              if (enable) cfg_nxt = cfg_in;
              else        state_nxt = ST_IDLE;
            end else begin
              line_nxt = line_cnt + 1'b1;
            end
          end else begin
            byte_nxt = byte_cnt + 1'b1;
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
    vsync_nxt = (state_nxt == ST_FRAME) && (int'(line_nxt) < VSYNC_LINES);
    href_nxt  = (state_nxt == ST_FRAME) && (int'(line_nxt) >= V_BLANK_LINES)
                && (int'(byte_nxt) < 2 * H_PIXELS);
    data_nxt  = href_nxt ? rgb444_byte(px, ~byte_nxt[0]) : 8'h00;
  end

  // State, counters and registered camera outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      byte_cnt    <= '0;
      line_cnt    <= '0;
      cfg         <= '0;
      frame_cnt   <= 8'd0;
      frame_done  <= 1'b0;
      CAM_vsync   <= 1'b0;
      CAM_href    <= 1'b0;
      CAM_px_data <= 8'h00;
    end else begin
      state       <= state_nxt;
      byte_cnt    <= byte_nxt;
      line_cnt    <= line_nxt;
      cfg         <= cfg_nxt;
      frame_cnt   <= frame_cnt_nxt;
      frame_done  <= done_nxt;
      CAM_vsync   <= vsync_nxt;
      CAM_href    <= href_nxt;
      CAM_px_data <= data_nxt;
    end
  end

endmodule

// File: tb/tb_cam_stream_gen.sv
// Bench for cam_stream_gen using a small 4-pixel, 4-line frame geometry.
// Latency: n/a.
// Backpressure: n/a.
module tb_cam_stream_gen;

  localparam int H_PIXELS      = 4;
  localparam int V_LINES       = 2;
  localparam int H_BLANK_BYTES = 2;
  localparam int V_BLANK_LINES = 2;
  localparam int VSYNC_LINES   = 1;
  localparam int PCLK_DIV      = 4;

  // Expected bytes of one 10-slot line, first slot in the top byte.
  localparam logic [79:0] L_SOLID = 80'h0F000F000F000F000000;
  localparam logic [79:0] L_V     = 80'h000F000F00F000F00000;
  localparam logic [79:0] L_C1    = 80'h00F000F0000F000F0000;
  localparam logic [79:0] L_H     = 80'h000F000F000F000F0000;
  localparam logic [79:0] L_H1    = 80'h00F000F000F000F00000;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [11:0] color_a;
  logic [11:0] color_b;

  logic        CAM_pclk, CAM_vsync, CAM_href, frame_done;
  logic [7:0]  CAM_px_data, frame_cnt;
  logic        pclk_h1, vsync_h1, href_h1, done_h1;
  logic [7:0]  data_h1, cnt_h1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_done_cyc = 0;
  int prev_done_cyc = 0;

  cam_stream_gen #(
    .H_PIXELS(H_PIXELS), .V_LINES(V_LINES), .H_BLANK_BYTES(H_BLANK_BYTES),
    .V_BLANK_LINES(V_BLANK_LINES), .VSYNC_LINES(VSYNC_LINES), .PCLK_DIV(PCLK_DIV),
    .STRIPE_W(2), .STRIPE_H(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .color_a(color_a), .color_b(color_b),
    .CAM_pclk(CAM_pclk), .CAM_vsync(CAM_vsync), .CAM_href(CAM_href),
    .CAM_px_data(CAM_px_data), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  cam_stream_gen #(
    .H_PIXELS(H_PIXELS), .V_LINES(V_LINES), .H_BLANK_BYTES(H_BLANK_BYTES),
    .V_BLANK_LINES(V_BLANK_LINES), .VSYNC_LINES(VSYNC_LINES), .PCLK_DIV(PCLK_DIV),
    .STRIPE_W(2), .STRIPE_H(1)
  ) dut_h1 (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode),
    .color_a(color_a), .color_b(color_b),
    .CAM_pclk(pclk_h1), .CAM_vsync(vsync_h1), .CAM_href(href_h1),
    .CAM_px_data(data_h1), .frame_done(done_h1), .frame_cnt(cnt_h1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] lbyte(input logic [79:0] l, input int b);
    return l[79-8*b -: 8];
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance to the next CAM_pclk rising edge, sampled on clk negedges.
  task automatic next_slot();
    logic seen_low;
    bit   found;
    seen_low = (CAM_pclk == 1'b0);
    found    = 1'b0;
    for (int i = 0; i < 2 * PCLK_DIV && !found; i++) begin
      @(negedge clk);
      if (!seen_low) seen_low = (CAM_pclk == 1'b0);
      else if (CAM_pclk) found = 1'b1;
    end
    chk("pclk_rise", {31'd0, found}, 32'd1);
  endtask

  task automatic sync_frame();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      next_slot();
      found = (CAM_vsync === 1'b1);
    end
    chk("frame_start", {31'd0, found}, 32'd1);
  endtask

  // Check the 40 slots of a frame, starting at slot 0 already sampled.
  task automatic check_frame(input string tag, input logic [79:0] l2, input logic [79:0] l3,
                             input logic [79:0] l3_h1, input int chg_at,
                             input logic [1:0] chg_mode, input logic chg_en);
    for (int s = 0; s < 40; s++) begin
      int ln;
      int b;
      logic ev, eh;
      logic [7:0] ed, ed1;
      if (s > 0) next_slot();
      ln  = s / 10;
      b   = s % 10;
      ev  = (ln < VSYNC_LINES);
      eh  = (ln >= V_BLANK_LINES) && (b < 2 * H_PIXELS);
      ed  = (ln == 2) ? lbyte(l2, b) : (ln == 3) ? lbyte(l3, b) : 8'h00;
      ed1 = (ln == 2) ? lbyte(l2, b) : (ln == 3) ? lbyte(l3_h1, b) : 8'h00;
      chk({tag, "_vsync"}, {31'd0, CAM_vsync}, {31'd0, ev});
      chk({tag, "_href"}, {31'd0, CAM_href}, {31'd0, eh});
      chk({tag, "_data"}, {24'd0, CAM_px_data}, {24'd0, ed});
      chk({tag, "_vsync_h1"}, {31'd0, vsync_h1}, {31'd0, ev});
      chk({tag, "_href_h1"}, {31'd0, href_h1}, {31'd0, eh});
      chk({tag, "_data_h1"}, {24'd0, data_h1}, {24'd0, ed1});
      if (s == chg_at) begin
        mode   = chg_mode;
        enable = chg_en;
      end
    end
  endtask

  task automatic wait_done(input string tag, input logic [7:0] exp_cnt);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      found = (frame_done === 1'b1);
    end
    chk({tag, "_done_seen"}, {31'd0, found}, 32'd1);
    chk({tag, "_done_h1"}, {31'd0, done_h1}, 32'd1);
    chk({tag, "_frame_cnt"}, {24'd0, frame_cnt}, {24'd0, exp_cnt});
    chk({tag, "_frame_cnt_h1"}, {24'd0, cnt_h1}, {24'd0, exp_cnt});
    prev_done_cyc = last_done_cyc;
    last_done_cyc = cyc;
    @(negedge clk);
    chk({tag, "_done_width"}, {31'd0, frame_done}, 32'd0);
  endtask

  initial begin
    int  n;
    bit  seen_low;
    bit  found;
    bit  idle_bad;

    // Reset held, then released with enable low.
    rst = 1'b0; enable = 1'b0; mode = 2'd0; color_a = 12'h000; color_b = 12'h000;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {13'd0, CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done, frame_cnt}, 32'd0);
    chk("reset_outputs_h1", {13'd0, pclk_h1, vsync_h1, href_h1, data_h1, done_h1, cnt_h1}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("pclk_low_half", {31'd0, CAM_pclk}, 32'd0);
    @(negedge clk);
    chk("pclk_first_rise", {31'd0, CAM_pclk}, 32'd1);
    n = 0; seen_low = 1'b0; found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      n++;
      if (!seen_low) seen_low = !CAM_pclk;
      else if (CAM_pclk) found = 1'b1;
    end
    chk("pclk_period", n, 32'd4);
    idle_bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (CAM_vsync || CAM_href || CAM_px_data != 8'h00 || frame_done || frame_cnt != 8'd0)
        idle_bad = 1'b1;
    end
    chk("idle_quiet", {31'd0, idle_bad}, 32'd0);

    // Solid colour A, continuous frames.
    mode = 2'd0; color_a = 12'hF00; color_b = 12'h000; enable = 1'b1;
    sync_frame();
    check_frame("solid1", L_SOLID, L_SOLID, L_SOLID, -1, 2'd0, 1'b1);
    wait_done("f1", 8'd1);
    next_slot();
    check_frame("solid2", L_SOLID, L_SOLID, L_SOLID, -1, 2'd0, 1'b1);
    wait_done("f2", 8'd2);
    chk("frame_period", last_done_cyc - prev_done_cyc, 32'd160);

    // New settings arrive just after a frame has latched its config.
    mode = 2'd1; color_a = 12'h00F; color_b = 12'h0F0;
    next_slot();
    check_frame("solid3_latched", L_SOLID, L_SOLID, L_SOLID, -1, 2'd0, 1'b1);
    wait_done("f3", 8'd3);
    next_slot();
    check_frame("vstripe4", L_V, L_V, L_V, 20, 2'd3, 1'b1);
    wait_done("f4", 8'd4);
    next_slot();
    check_frame("checker5", L_V, L_V, L_C1, 25, 2'd1, 1'b1);
    wait_done("f5", 8'd5);
    next_slot();
    check_frame("vstripe6", L_V, L_V, L_V, 25, 2'd2, 1'b1);
    wait_done("f6", 8'd6);
    next_slot();
    check_frame("hstripe7", L_H, L_H, L_H1, 15, 2'd2, 1'b0);
    wait_done("f7", 8'd7);

    // Enable dropped mid-frame: generator must now sit idle.
    idle_bad = 1'b0;
    repeat (200) begin
      @(negedge clk);
      if (CAM_vsync || CAM_href || CAM_px_data != 8'h00 || frame_done || frame_cnt != 8'd7)
        idle_bad = 1'b1;
    end
    chk("idle_after_disable", {31'd0, idle_bad}, 32'd0);

    // Asynchronous reset in the middle of an active line.
    enable = 1'b1;
    sync_frame();
    repeat (23) next_slot();
    chk("pre_reset_href", {31'd0, CAM_href}, 32'd1);
    chk("pre_reset_data", {24'd0, CAM_px_data}, 32'h0F);
    rst = 1'b0;
    #1;
    chk("async_reset", {13'd0, CAM_pclk, CAM_vsync, CAM_href, CAM_px_data, frame_done, frame_cnt}, 32'd0);
    chk("async_reset_h1", {13'd0, pclk_h1, vsync_h1, href_h1, data_h1, done_h1, cnt_h1}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // 256 frames: counter wraps back to zero.
    for (int i = 1; i <= 256; i++) begin
      wait_done("wrap", 8'(i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
